// File: rtl/btn_conditioner_pkg.sv
// Shared timing constants and channel state encoding for the push-button conditioner.
// Parameter defaults of btn_conditioner derive from the constants below.
package btn_conditioner_pkg;

    localparam int CLOCK_FREQ      = 50_000_000;
    localparam int BTN_DEBOUNCE_MS = 20;
    localparam int BTN_LONG_MS     = 1000;

    localparam int DEF_DEBOUNCE_CYCLES = (CLOCK_FREQ / 1000) * BTN_DEBOUNCE_MS;
    localparam int DEF_LONG_CYCLES     = (CLOCK_FREQ / 1000) * BTN_LONG_MS;

    typedef enum logic [1:0] {
        BTN_RELEASED     = 2'd0,
        BTN_PRESS_PEND   = 2'd1,
        BTN_HELD         = 2'd2,
        BTN_RELEASE_PEND = 2'd3
    } btn_state_t;

    // Counter width for a count that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM, press/release pulses and
// optional long-press pulse (built only when BTN_LONGPRESS_EN is defined).
module btn_debounce_ch
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_check
        $error("btn_debounce_ch: need DEBOUNCE_CYCLES >= 1 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end

    logic            r_s0;
    logic            r_s1;
    logic [DW-1:0]   r_dcnt;
    btn_state_t      r_state;
    logic            r_level;
    logic            r_press;
    logic            r_release;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else begin
            r_s0 <= btn_raw;
            r_s1 <= r_s0;
        end
    end

    // Any sample that agrees with the current level aborts a pending change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= BTN_RELEASED;
            r_dcnt    <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                BTN_RELEASED, BTN_PRESS_PEND: begin
                    if (r_s1) begin
                        if (r_dcnt == DB_LAST) begin
                            r_state <= BTN_HELD;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                            r_dcnt  <= '0;
                        end else begin
                            r_state <= BTN_PRESS_PEND;
                            r_dcnt  <= r_dcnt + DW'(1);
                        end
                    end else begin
                        r_state <= BTN_RELEASED;
                        r_dcnt  <= '0;
                    end
                end
                BTN_HELD, BTN_RELEASE_PEND: begin
                    if (!r_s1) begin
                        if (r_dcnt == DB_LAST) begin
                            r_state   <= BTN_RELEASED;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                            r_dcnt    <= '0;
                        end else begin
                            r_state <= BTN_RELEASE_PEND;
                            r_dcnt  <= r_dcnt + DW'(1);
                        end
                    end else begin
                        r_state <= BTN_HELD;
                        r_dcnt  <= '0;
                    end
                end
                default: begin
                    r_state <= BTN_RELEASED;
                    r_dcnt  <= '0;
                end
            endcase
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

`ifdef BTN_LONGPRESS_EN
    localparam int LW = cnt_width(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] r_lcnt;
    logic          r_ldone;
    logic          r_long;

    // Keyed on the debounced level, so a bounce through RELEASE_PEND keeps the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lcnt  <= '0;
            r_ldone <= 1'b0;
            r_long  <= 1'b0;
        end else if (!r_level) begin
            r_lcnt  <= '0;
            r_ldone <= 1'b0;
            r_long  <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (r_lcnt == LONG_LAST) begin
                if (!r_ldone) begin
                    r_long  <= 1'b1;
                    r_ldone <= 1'b1;
                end
            end else begin
                r_lcnt <= r_lcnt + LW'(1);
            end
        end
    end

    assign btn_long = r_long;
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: N_BTN independent debounce channels feeding the top FSM.
// Long-press pulses are built only when BTN_LONGPRESS_EN is defined; otherwise btn_long is 0.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_long    (btn_long[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
module tb_btn_conditioner;

    localparam int N  = 3;
    localparam int DB = 4;
    localparam int LC = 16;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_long;

    int n_checks;
    int n_fail;

    btn_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int press_cnt, rel_cnt, long_cnt, press_edge, long_edge, rise_edge;
    logic [11:0] any_out;
    logic [N-1:0] pat [1:20];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        btn_raw  = 3'b111;

        // Reset held with raw high
        tick(5);
        chk("rst_level",   32'(btn_level),   32'h0);
        chk("rst_press",   32'(btn_press),   32'h0);
        chk("rst_release", 32'(btn_release), 32'h0);
        chk("rst_long",    32'(btn_long),    32'h0);

        rst = 1'b1;
        tick(5);
        chk("rr_press_e5", 32'(btn_press), 32'h0);
        tick(1);
        chk("rr_press_e6", 32'(btn_press), 32'h7);
        chk("rr_level_e6", 32'(btn_level), 32'h7);
        tick(1);
        chk("rr_press_e7", 32'(btn_press), 32'h0);

        btn_raw = 3'b000;
        tick(5);
        chk("rr_rel_e5", 32'(btn_release), 32'h0);
        tick(1);
        chk("rr_rel_e6", 32'(btn_release), 32'h7);
        chk("rr_lvl_off", 32'(btn_level), 32'h0);
        tick(1);
        chk("rr_rel_e7", 32'(btn_release), 32'h0);
        tick(10);

        // Clean press on ch1, held 10 cycles
        btn_raw = 3'b010;
        tick(5);
        chk("c1_level_e5", 32'(btn_level), 32'h0);
        tick(1);
        chk("c1_level_e6", 32'(btn_level), 32'h2);
        chk("c1_press_e6", 32'(btn_press), 32'h2);
        tick(1);
        chk("c1_press_e7", 32'(btn_press), 32'h0);
        tick(3);
        btn_raw = 3'b000;
        tick(5);
        chk("c1_rel_e5", 32'(btn_release), 32'h0);
        tick(1);
        chk("c1_rel_e6", 32'(btn_release), 32'h2);
        chk("c1_lvl_e6", 32'(btn_level), 32'h0);
        tick(1);
        chk("c1_rel_e7", 32'(btn_release), 32'h0);
        tick(10);

        // Glitch then bounce on ch0; final rising sample on edge 10
        for (int e = 1; e <= 20; e++) pat[e] = 3'b001;
        pat[4] = 3'b000; pat[5] = 3'b000; pat[7] = 3'b000; pat[9] = 3'b000;
        press_cnt = 0; rel_cnt = 0; press_edge = 0;
        for (int e = 1; e <= 20; e++) begin
            btn_raw = pat[e];
            tick(1);
            if (btn_press[0]) begin
                press_cnt++;
                press_edge = e;
            end
            if (btn_release[0]) rel_cnt++;
        end
        chk("bn_press_cnt",  32'(press_cnt),  32'd1);
        chk("bn_press_edge", 32'(press_edge), 32'd15);
        chk("bn_rel_cnt",    32'(rel_cnt),    32'd0);
        chk("bn_level",      32'(btn_level),  32'h1);
        btn_raw = 3'b000;
        tick(12);

        // Long hold on ch2 for 40 cycles
        btn_raw = 3'b100;
        long_cnt = 0; long_edge = 0; rise_edge = 0;
        for (int e = 1; e <= 40; e++) begin
            tick(1);
            if (btn_press[2]) rise_edge = e;
            if (btn_long[2]) begin
                long_cnt++;
                long_edge = e;
            end
        end
        chk("lp_rise_edge", 32'(rise_edge), 32'd6);
`ifdef BTN_LONGPRESS_EN
        chk("lp_long_cnt",  32'(long_cnt),  32'd1);
        chk("lp_long_edge", 32'(long_edge), 32'd22);
`else
        chk("lp_long_cnt",  32'(long_cnt),  32'd0);
`endif
        btn_raw = 3'b000;
        tick(12);

        // ch0 and ch2 on the same edge
        btn_raw = 3'b101;
        tick(5);
        chk("sim_press_e5", 32'(btn_press), 32'h0);
        tick(1);
        chk("sim_press_e6", 32'(btn_press), 32'h5);
        tick(1);
        chk("sim_press_e7", 32'(btn_press), 32'h0);
        btn_raw = 3'b000;
        tick(12);

        // Reset mid-count on ch1, raw dropped before reset release
        btn_raw = 3'b010;
        tick(4);
        rst = 1'b0;
        #1;
        chk("mr_async_clear", 32'({btn_level, btn_press, btn_release, btn_long}), 32'h0);
        btn_raw = 3'b000;
        tick(2);
        rst = 1'b1;
        any_out = '0;
        for (int e = 1; e <= 12; e++) begin
            tick(1);
            any_out = any_out | {btn_level, btn_press, btn_release, btn_long};
        end
        chk("mr_quiet", 32'(any_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end conditioner for the board push-buttons (BTN0 reset/stop, BTN1 state change, BTN2 colour). It sits directly upstream of the top-level state machine. Per button it:
- synchronises the raw input to `clk`;
- debounces it with a stable-time counter;
- emits a clean level plus single-cycle press and release pulses.

The state machine consumes these pulses as its `rst`, `state_change` and `state_color` inputs, so a bouncing contact produces exactly one state transition.

## Interface
Parameters:
- `N_BTN`, 3, number of independent button channels.
- `DEBOUNCE_CYCLES`, `CLOCK_FREQ/50` (20 ms), required stable time in clk cycles; must be ≥ 1.
- `LONG_CYCLES`, `CLOCK_FREQ` (1 s), hold time for a long-press pulse; must be > `DEBOUNCE_CYCLES`.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  N_BTN  raw buttons, active-high, asynchronous to `clk`.
- `btn_level`  out  N_BTN  debounced button level.
- `btn_press`  out  N_BTN  one-cycle pulse on a debounced 0→1 transition.
- `btn_release`  out  N_BTN  one-cycle pulse on a debounced 1→0 transition.
- `btn_long`  out  N_BTN  one-cycle pulse after `LONG_CYCLES` of continuous debounced hold.

## Operation
- Channels are fully independent. Any combination may change in the same cycle, and each channel behaves as if alone.
- Each channel passes `btn_raw[i]` through a 2-FF synchroniser (`s0`, then `s1`). Only `s1` is used downstream.
- Per-channel states:
  - RELEASED: level 0, `s1` = 0.
  - PRESS_PEND: level 0, `s1` = 1, counting.
  - HELD: level 1, `s1` = 1, long-press counting.
  - RELEASE_PEND: level 1, `s1` = 0, counting.
- Debounce counter rules:
  - It increments on every edge where `s1` ≠ `btn_level`.
  - On any edge where `s1` = `btn_level` it clears to 0. Any glitch shorter than `DEBOUNCE_CYCLES` therefore aborts with no output change.
  - On an edge where the counter = `DEBOUNCE_CYCLES-1` and `s1` still differs: `btn_level` toggles, the counter clears, and `btn_press` (entering HELD) or `btn_release` (entering RELEASED) pulses for exactly one cycle.
- Long-press counter:
  - Counts only in HELD, starting from 0 on entry.
  - `btn_long` pulses once when the count reaches `LONG_CYCLES-1`.
  - The counter then saturates: no repeat until the channel leaves and re-enters HELD.
  - Counting continues through RELEASE_PEND; a bounce that returns to HELD does not restart the long-press count.
- Counter widths are `$clog2(DEBOUNCE_CYCLES)` and `$clog2(LONG_CYCLES)` (minimum 1). Counters never wrap.
- Reset (asserted low, any time, including mid-count or mid-pulse): all sync flops, counters and outputs clear to 0 immediately. A button held through reset release is seen as a fresh press after the full debounce time.

## Timing
- All outputs are registered, and all reset to 0.
- Press latency: number the first rising edge that samples `btn_raw[i]` = 1 as edge 1. `btn_level[i]` and `btn_press[i]` go high after edge `DEBOUNCE_CYCLES+2`, and `btn_press[i]` drops after the next edge.
- Release latency is identical, measured from the first edge that samples 0.
- `btn_long` goes high after the (`LONG_CYCLES`)th edge following the edge on which `btn_level` rose.
- `btn_press` and `btn_release` are never high together on one channel. The minimum spacing between them is `DEBOUNCE_CYCLES` cycles.

## Configuration
- `BTN_LONGPRESS_EN` defined: long-press counter and `btn_long` logic are built as described above.
- Not defined:
  - the long-press counter is not synthesised;
  - `btn_long` is tied to 0;
  - the port list is unchanged, so parent instantiations need no edits.

## Structure
- `CLOCK_FREQ` and the default debounce and long-press times (`BTN_DEBOUNCE_MS`, `BTN_LONG_MS`) belong in the shared `system_para.v`. The parameter defaults derive from them.
- The channel state encodings belong in a shared `btn_state.v` include.
- One sub-module, `btn_debounce_ch`, holds the synchroniser, debounce FSM and long-press counter for one channel. `btn_conditioner` instantiates it `N_BTN` times in a generate loop.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=16, `BTN_LONGPRESS_EN` defined.
- Reset held low, `btn_raw`=3'b111 → all outputs 0. Release reset with raw still high → `btn_press` pulses after edge 6 post-release; `btn_level`=3'b111.
- Clean press on ch1 (raw high from edge 1, held 10 cycles) → `btn_level[1]`=1 and `btn_press[1]`=1 after edge 6, `btn_press[1]`=0 after edge 7. Release → `btn_release[1]` pulses 6 edges after the first low sample.
- 3-cycle glitch on ch0, then bounce pattern 1,0,1,0 followed by stable 1 → exactly one `btn_press[0]` pulse, 6 edges after the final rising sample; no `btn_release`.
- Hold ch2 for 40 cycles → one `btn_long[2]` pulse 16 edges after `btn_level[2]` rises, no second pulse. Rebuild without `BTN_LONGPRESS_EN` → `btn_long` stays 0.
- ch0 and ch2 pressed on the same edge → simultaneous `btn_press`=3'b101 pulse.
- Reset asserted 2 cycles into a press count on ch1, then raw dropped before reset release → no pulse on any output; all outputs stay 0.
